// File: rtl/cluster_pkg.sv
// cluster_pkg: types and constants shared by the PE_cluster load controller.
//   load_state_t : load/config FSM states
//   mcn_tag_t    : multicast (y,x) target entry
//   MCN_TAG_NONE : all-ones "no target" tag
package cluster_pkg;

  localparam int ID_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    LOAD_A    = 3'd2,
    DRAIN     = 3'd3,
    START     = 3'd4,
    WAIT_DONE = 3'd5
  } load_state_t;

  typedef struct packed {
    logic [ID_SIZE-1:0] y;
    logic [ID_SIZE-1:0] x;
  } mcn_tag_t;

  localparam mcn_tag_t MCN_TAG_NONE = '{y: '1, x: '1};

endpackage

// File: rtl/mcn_tag_table.sv
// mcn_tag_table: register file of multicast tags, one write port and one
// combinational read port. Entries reset to MCN_TAG_NONE.
// Ports:
//   clk, nrst        clock, async active-low reset
//   wr_en            write strobe (indices >= DEPTH are dropped)
//   wr_idx           write index
//   wr_y, wr_x       write data
//   rd_idx           read index (one bit wider than needed; out-of-range
//                    reads return MCN_TAG_NONE)
//   rd_y, rd_x       read data
module mcn_tag_table
  import cluster_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ID_SIZE-1:0] wr_y,
  input  logic [ID_SIZE-1:0] wr_x,
  input  logic [IDX_W:0]     rd_idx,
  output logic [ID_SIZE-1:0] rd_y,
  output logic [ID_SIZE-1:0] rd_x
);

  mcn_tag_t tbl_q [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= MCN_TAG_NONE;
    end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
      tbl_q[wr_idx] <= '{y: wr_y, x: wr_x};
    end
  end

  always_comb begin
    rd_y = MCN_TAG_NONE.y;
    rd_x = MCN_TAG_NONE.x;
    if (int'(rd_idx) < DEPTH) begin
      rd_y = tbl_q[rd_idx[IDX_W-1:0]].y;
      rd_x = tbl_q[rd_idx[IDX_W-1:0]].x;
    end
  end

endmodule

// File: rtl/cluster_load_ctrl.sv
// cluster_load_ctrl: streams weights then activations from two synchronous
// buffers (1-cycle read latency) into PE_cluster, tagging each beat with a
// multicast (y,x) target from per-phase tag-order tables, then kicks off
// compute and tracks completion.
//
// Build option: CLUSTER_LOAD_CTRL_WAIT_DONE_EN
//   defined   -> START goes to WAIT_DONE; done_o follows flag_done_i there
//   undefined -> START returns to IDLE; done_o pulses the cycle after
//                start_compute_o and flag_done_i is ignored
//
// Ports:
//   clk, nrst                      clock, async active-low reset
//   start_i                        one-cycle start pulse (ignored when busy)
//   ctrl_wcount, ctrl_acount       beats per weight / act tag
//   w_num_tags_i, a_num_tags_i     tags per phase
//   tag_wr_*                       tag table write port (IDLE only)
//   w_rd_*, a_rd_*                 buffer read ports
//   w_data_o, a_data_o             data to cluster
//   *_mcn_tag_target_{y,x}_o       tag of the beat on *_data_o
//   start_compute_o                compute kick to cluster
//   flag_done_i                    cluster completion flag
//   busy_o, done_o                 status
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start_i; tag tables writable
// LOAD_W    | one weight read per cycle
// LOAD_A    | one act read per cycle
// DRAIN     | final beat of the last phase is on the data outputs
// START     | start_compute_o high
// WAIT_DONE | waiting for flag_done_i
module cluster_load_ctrl
  import cluster_pkg::*;
#(
  parameter int dataSize = 8,
  parameter int idSize   = 8,
  parameter int addrSize = 16,
  parameter int maxTags  = 16
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       start_i,
  input  logic [7:0]                 ctrl_wcount,
  input  logic [7:0]                 ctrl_acount,
  input  logic [$clog2(maxTags):0]   w_num_tags_i,
  input  logic [$clog2(maxTags):0]   a_num_tags_i,
  input  logic                       tag_wr_en_i,
  input  logic                       tag_wr_sel_i,
  input  logic [$clog2(maxTags)-1:0] tag_wr_idx_i,
  input  logic [idSize-1:0]          tag_wr_y_i,
  input  logic [idSize-1:0]          tag_wr_x_i,
  output logic                       w_rd_en_o,
  output logic                       a_rd_en_o,
  output logic [addrSize-1:0]        w_rd_addr_o,
  output logic [addrSize-1:0]        a_rd_addr_o,
  input  logic [dataSize-1:0]        w_rd_data_i,
  input  logic [dataSize-1:0]        a_rd_data_i,
  output logic [dataSize-1:0]        w_data_o,
  output logic [dataSize-1:0]        a_data_o,
  output logic [idSize-1:0]          weight_mcn_tag_target_y_o,
  output logic [idSize-1:0]          weight_mcn_tag_target_x_o,
  output logic [idSize-1:0]          act_mcn_tag_target_y_o,
  output logic [idSize-1:0]          act_mcn_tag_target_x_o,
  output logic                       start_compute_o,
  input  logic                       flag_done_i,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int NTAG_W = $clog2(maxTags) + 1;

  load_state_t state_q, state_d;

  logic [7:0]          wcount_q, acount_q;
  logic [NTAG_W-1:0]   wtags_q, atags_q;
  logic [7:0]          beat_q;
  logic [NTAG_W-1:0]   tag_q;
  logic [addrSize-1:0] addr_q;
  logic                w_vld_q, a_vld_q;
  logic [NTAG_W-1:0]   w_tag_idx_q, a_tag_idx_q;

  logic              rd_w, rd_a, start_cmp;
  logic              w_empty_in, a_empty_in, a_empty_q;
  logic [7:0]        cur_count;
  logic [NTAG_W-1:0] cur_tags;
  logic              beat_wrap, last_rd;
  logic [idSize-1:0] w_tbl_y, w_tbl_x, a_tbl_y, a_tbl_x;

`ifdef CLUSTER_LOAD_CTRL_WAIT_DONE_EN
  logic done_comb;
`else
  logic done_q;
  logic unused_flag_done;
  assign unused_flag_done = flag_done_i;
`endif

  // Emptiness is judged on the live inputs in IDLE (registers not loaded
  // yet) and on the sampled copies once running.
  assign w_empty_in = (w_num_tags_i == '0) || (ctrl_wcount == 8'd0);
  assign a_empty_in = (a_num_tags_i == '0) || (ctrl_acount == 8'd0);
  assign a_empty_q  = (atags_q == '0) || (acount_q == 8'd0);

  assign cur_count = (state_q == LOAD_A) ? acount_q : wcount_q;
  assign cur_tags  = (state_q == LOAD_A) ? atags_q  : wtags_q;
  assign beat_wrap = (beat_q == cur_count - 8'd1);
  assign last_rd   = beat_wrap && (tag_q == cur_tags - NTAG_W'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_w      = 1'b0;
    rd_a      = 1'b0;
    start_cmp = 1'b0;
`ifdef CLUSTER_LOAD_CTRL_WAIT_DONE_EN
    done_comb = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (!w_empty_in)      state_d = LOAD_W;
          else if (!a_empty_in) state_d = LOAD_A;
          else                  state_d = START;
        end
      end
      LOAD_W: begin
        rd_w = 1'b1;
        if (last_rd) state_d = a_empty_q ? DRAIN : LOAD_A;
      end
      LOAD_A: begin
        rd_a = 1'b1;
        if (last_rd) state_d = DRAIN;
      end
      DRAIN: state_d = START;
      START: begin
        start_cmp = 1'b1;
`ifdef CLUSTER_LOAD_CTRL_WAIT_DONE_EN
        state_d = WAIT_DONE;
`else
        state_d = IDLE;
`endif
      end
      WAIT_DONE: begin
`ifdef CLUSTER_LOAD_CTRL_WAIT_DONE_EN
        if (flag_done_i) begin
          done_comb = 1'b1;
          state_d   = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcount_q <= '0;
      acount_q <= '0;
      wtags_q  <= '0;
      atags_q  <= '0;
    end else if ((state_q == IDLE) && start_i) begin
      wcount_q <= ctrl_wcount;
      acount_q <= ctrl_acount;
      wtags_q  <= w_num_tags_i;
      atags_q  <= a_num_tags_i;
    end
  end

  // Any state change restarts beat, tag and address counting, so each
  // phase begins at address 0 and tag 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat_q <= '0;
      tag_q  <= '0;
      addr_q <= '0;
    end else if (state_d != state_q) begin
      beat_q <= '0;
      tag_q  <= '0;
      addr_q <= '0;
    end else if (rd_w || rd_a) begin
      addr_q <= addr_q + addrSize'(1);
      if (beat_wrap) begin
        beat_q <= '0;
        tag_q  <= tag_q + NTAG_W'(1);
      end else begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  // Tag index travels one cycle behind the read so it lines up with data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_vld_q     <= 1'b0;
      a_vld_q     <= 1'b0;
      w_tag_idx_q <= '0;
      a_tag_idx_q <= '0;
    end else begin
      w_vld_q     <= rd_w;
      a_vld_q     <= rd_a;
      w_tag_idx_q <= rd_w ? tag_q : '0;
      a_tag_idx_q <= rd_a ? tag_q : '0;
    end
  end

`ifndef CLUSTER_LOAD_CTRL_WAIT_DONE_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) done_q <= 1'b0;
    else       done_q <= (state_q == START);
  end
`endif

  mcn_tag_table #(.DEPTH(maxTags)) u_w_tags (
    .clk    (clk),
    .nrst   (nrst),
    .wr_en  (tag_wr_en_i && (state_q == IDLE) && !tag_wr_sel_i),
    .wr_idx (tag_wr_idx_i),
    .wr_y   (tag_wr_y_i),
    .wr_x   (tag_wr_x_i),
    .rd_idx (w_tag_idx_q),
    .rd_y   (w_tbl_y),
    .rd_x   (w_tbl_x)
  );

  mcn_tag_table #(.DEPTH(maxTags)) u_a_tags (
    .clk    (clk),
    .nrst   (nrst),
    .wr_en  (tag_wr_en_i && (state_q == IDLE) && tag_wr_sel_i),
    .wr_idx (tag_wr_idx_i),
    .wr_y   (tag_wr_y_i),
    .wr_x   (tag_wr_x_i),
    .rd_idx (a_tag_idx_q),
    .rd_y   (a_tbl_y),
    .rd_x   (a_tbl_x)
  );

  assign w_rd_en_o   = rd_w;
  assign a_rd_en_o   = rd_a;
  assign w_rd_addr_o = rd_w ? addr_q : '0;
  assign a_rd_addr_o = rd_a ? addr_q : '0;

  assign w_data_o = w_vld_q ? w_rd_data_i : '0;
  assign a_data_o = a_vld_q ? a_rd_data_i : '0;
  assign weight_mcn_tag_target_y_o = w_vld_q ? w_tbl_y : '1;
  assign weight_mcn_tag_target_x_o = w_vld_q ? w_tbl_x : '1;
  assign act_mcn_tag_target_y_o    = a_vld_q ? a_tbl_y : '1;
  assign act_mcn_tag_target_x_o    = a_vld_q ? a_tbl_x : '1;

  assign start_compute_o = start_cmp;
  assign busy_o          = (state_q != IDLE);
`ifdef CLUSTER_LOAD_CTRL_WAIT_DONE_EN
  assign done_o = done_comb;
`else
  assign done_o = done_q;
`endif

endmodule
